rand_arbiter: RTL and testbench
===============================

# rand_arbiter

Round-robin arbiter and sequencer for a shared 13-bit Fibonacci LFSR random source. The block grants the LFSR to one of `N_REQ` requesters at a time and clocks it through 13 shifts so every delivered word is fully refreshed. It returns the word with a one-cycle acknowledge. It sits between game-logic clients (spawners, movers, scorers) and the random source, so the clients never drive the shift register directly.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `SEED`, 13'h000F: LFSR reset value; must be nonzero.
- `MAX_RETRY`, 3: maximum rejections per request; used only with `RAND_LIMIT_EN`.
- `clock` input 1: rising-edge clock.
- `resetn` input 1: asynchronous, active-low reset.
- `req` input N_REQ: level request, one bit per requester.
- `limit` input 13: inclusive upper bound, sampled at grant; used only with `RAND_LIMIT_EN`.
- `grant` output N_REQ: one-hot owner, held from acceptance through the ack cycle.
- `ack` output N_REQ: one-hot one-cycle pulse that marks `rnd` valid for the granted requester.
- `rnd` output 13: delivered random word, registered; holds until the next delivery.
- `busy` output 1: high in SHIFT and DONE.

## Operation
- **LFSR:** `lfsr <= {lfsr[11:0], fb}`, where `fb = lfsr[12]^lfsr[3]^lfsr[2]^lfsr[0]`.
  - The LFSR shifts only in SHIFT and never passes through all-zero.
- **FSM states:**
  - IDLE: no owner.
  - SHIFT: 13 shifts, counted by `cnt` running 0..12.
  - DONE: delivery or rejection.
- **IDLE:**
  - With `req` = 0, stay in IDLE.
  - Otherwise pick the first set bit at or after pointer `ptr`, wrapping modulo N_REQ.
  - Load `grant`, capture `limit` into `limit_q`, clear `cnt` and `retry`, and go to SHIFT.
  - `ptr` ← granted index + 1, wrapping.
- **SHIFT:**
  - Shift and increment `cnt` each edge.
  - At the edge where `cnt` == 12, shift and go to DONE.
- **DONE:**
  - `ack[g]` = 1 and `rnd` = `lfsr` (registered on entry), then go to IDLE.
  - With `RAND_LIMIT_EN`, a rejection returns to SHIFT instead; see Configuration.
- **Request rules:**
  - Requests are sampled only in IDLE. `req` changes during SHIFT/DONE have no effect on the current transaction.
  - A requester whose `req` drops mid-transaction still gets its ack; the value is discarded by the client.
  - A requester deasserts `req` by the edge after its ack, otherwise it is re-served.
- **Reset (`resetn` low, any time):**
  - state = IDLE, `lfsr` = SEED, `cnt` = 0, `retry` = 0, `ptr` = 0.
  - `grant` = 0, `ack` = 0, `rnd` = 0, `busy` = 0.
  - An in-flight transaction is dropped with no ack.

## Timing
- Acceptance edge = E0, the IDLE edge that loads `grant`.
- SHIFT occupies edges E1..E13; E13 enters DONE.
- `ack` and the new `rnd` are high/valid between E13 and E14; E14 returns to IDLE.
- Request-to-ack latency is 14 cycles. Each rejection adds 14 cycles.
- At least one IDLE cycle separates transactions, so back-to-back grants are 15 cycles apart.
- `busy` is high from E0 through E14, exclusive of E14.
- All outputs are registered; `grant` is stable for the whole transaction.

## Configuration
- Macro: `RAND_LIMIT_EN`.
- **Defined:** in DONE, if `lfsr > limit_q` and `retry < MAX_RETRY`:
  - Do not ack. Increment `retry`, clear `cnt`, and return to SHIFT for 13 more shifts.
  - If `retry == MAX_RETRY` and the value is still out of range, deliver `rnd = lfsr & limit_q`, which is guaranteed ≤ `limit_q`.
- **Undefined:** the `limit` port and `retry` logic are removed, and every DONE delivers.

## Test plan
- Reset, then `req` = 4'b0001 held → `grant` = 0001 at E0, `ack[0]` high 14 cycles later, `rnd` = 13'h1FF4.
- Then `req[0]` dropped and `req[0]` re-raised → second delivery `rnd` = 13'h05E4.
- `req` = 4'b1111 held continuously → grants rotate 0,1,2,3,0, each ack 15 cycles apart, exactly one `ack` bit at a time.
- Reset mid-SHIFT at cycle 7:
  - Required: all outputs 0 immediately, no ack.
  - Next `req[2]` yields `rnd` = 13'h1FF4, which proves the LFSR restarted from SEED.
- `RAND_LIMIT_EN`, `limit` = 13'h0FFF, reset, `req[1]`:
  - 0x1FF4 is rejected.
  - `ack[1]` follows at 28 cycles with `rnd` = 13'h05E4.
- `RAND_LIMIT_EN`, `limit` = 0:
  - Required: ack after (MAX_RETRY+1)·14 = 56 cycles with `rnd` = 0.
  - `req` toggles during SHIFT do not alter `grant`.

Source files
------------

// File: rtl/rand_arbiter.sv
// rand_arbiter: round-robin arbiter that shares one 13-bit Fibonacci LFSR
// between N_REQ requesters. Each grant clocks the LFSR through 13 shifts, so
// every delivered word is fully refreshed. The word is returned with a
// one-cycle acknowledge.
// Optional feature macro: RAND_LIMIT_EN. It adds a `limit` port. It also adds
// rejection resampling, with up to MAX_RETRY retries, followed by a final
// mask that forces the delivered word into range.
module rand_arbiter #(
  parameter int          N_REQ     = 4,
  parameter logic [12:0] SEED      = 13'h000F
`ifdef RAND_LIMIT_EN
  ,
  parameter int          MAX_RETRY = 3
`endif
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [N_REQ-1:0] req,
`ifdef RAND_LIMIT_EN
  input  logic [12:0]      limit,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] ack,
  output logic [12:0]      rnd,
  output logic             busy
);

  localparam int PW = $clog2(N_REQ);
`ifdef RAND_LIMIT_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_stateNext;
  logic [12:0]      r_lfsr, w_lfsrNext, w_lfsrShift;
  logic [3:0]       r_cnt, w_cntNext;
  logic [PW-1:0]    r_ptr, w_ptrNext, w_pickIdx;
  logic [N_REQ-1:0] r_grant, w_grantNext;
  logic [N_REQ-1:0] r_ack, w_ackNext;
  logic [12:0]      r_rnd, w_rndNext;
  logic             r_busy, w_busyNext;
  logic             w_found;
`ifdef RAND_LIMIT_EN
  logic [12:0]      r_limitQ, w_limitQNext;
  logic [RW-1:0]    r_retry, w_retryNext;
  logic             w_rejectShift, w_rejectHold;
`endif

  assign w_lfsrShift = {r_lfsr[11:0], r_lfsr[12] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0]};

`ifdef RAND_LIMIT_EN
  // The shift-time test decides at the DONE entry edge whether to ack. The
  // hold-time test repeats that decision in DONE; the LFSR is frozen in DONE.
  assign w_rejectShift = (w_lfsrShift > r_limitQ) && (r_retry < RW'(MAX_RETRY));
  assign w_rejectHold  = (r_lfsr > r_limitQ) && (r_retry < RW'(MAX_RETRY));
`endif

  // Round-robin pick: the first requesting index at or after the pointer, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_pickIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[(int'(r_ptr) + i) % N_REQ]) begin
        w_found   = 1'b1;
        w_pickIdx = PW'((int'(r_ptr) + i) % N_REQ);
      end
    end
  end

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    w_stateNext  = r_state;
    w_lfsrNext   = r_lfsr;
    w_cntNext    = r_cnt;
    w_ptrNext    = r_ptr;
    w_grantNext  = r_grant;
    w_ackNext    = '0;
    w_rndNext    = r_rnd;
    w_busyNext   = r_busy;
`ifdef RAND_LIMIT_EN
    w_limitQNext = r_limitQ;
    w_retryNext  = r_retry;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grantNext  = N_REQ'(1) << w_pickIdx;
          w_ptrNext    = (w_pickIdx == PW'(N_REQ - 1)) ? '0 : w_pickIdx + 1'b1;
          w_cntNext    = '0;
          w_busyNext   = 1'b1;
          w_stateNext  = S_SHIFT;
`ifdef RAND_LIMIT_EN
          w_limitQNext = limit;
          w_retryNext  = '0;
`endif
        end
      end
      S_SHIFT: begin
        w_lfsrNext = w_lfsrShift;
        w_cntNext  = r_cnt + 4'd1;
        if (r_cnt == 4'd12) begin
          w_cntNext   = '0;
          w_stateNext = S_DONE;
`ifdef RAND_LIMIT_EN
          if (!w_rejectShift) begin
            w_ackNext = r_grant;
            w_rndNext = (w_lfsrShift > r_limitQ) ? (w_lfsrShift & r_limitQ) : w_lfsrShift;
          end
`else
          w_ackNext = r_grant;
          w_rndNext = w_lfsrShift;
`endif
        end
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
        w_grantNext = '0;
        w_busyNext  = 1'b0;
`ifdef RAND_LIMIT_EN
        if (w_rejectHold) begin
          w_stateNext = S_SHIFT;
          w_grantNext = r_grant;
          w_busyNext  = 1'b1;
          w_cntNext   = '0;
          w_retryNext = r_retry + 1'b1;
        end
`endif
      end
      default: begin
        w_stateNext = S_IDLE;
        w_grantNext = '0;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction without an ack.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_rnd    <= '0;
      r_busy   <= 1'b0;
`ifdef RAND_LIMIT_EN
      r_limitQ <= '0;
      r_retry  <= '0;
`endif
    end else begin
      r_state  <= w_stateNext;
      r_lfsr   <= w_lfsrNext;
      r_cnt    <= w_cntNext;
      r_ptr    <= w_ptrNext;
      r_grant  <= w_grantNext;
      r_ack    <= w_ackNext;
      r_rnd    <= w_rndNext;
      r_busy   <= w_busyNext;
`ifdef RAND_LIMIT_EN
      r_limitQ <= w_limitQNext;
      r_retry  <= w_retryNext;
`endif
    end
  end

  assign grant = r_grant;
  assign ack   = r_ack;
  assign rnd   = r_rnd;
  assign busy  = r_busy;

endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter: directed bench for rand_arbiter with hand-computed LFSR
// words. The RAND_LIMIT_EN scenarios are compiled in only when that macro is defined.
module tb_rand_arbiter;

  localparam int N = 4;

  logic         clock;
  logic         resetn;
  logic [N-1:0] req;
`ifdef RAND_LIMIT_EN
  logic [12:0]  limit;
`endif
  logic [N-1:0] grant;
  logic [N-1:0] ack;
  logic [12:0]  rnd;
  logic         busy;

  int compareCount  = 0;
  int mismatchCount = 0;

  rand_arbiter #(.N_REQ(N), .SEED(13'h000F)) dut (
    .clock (clock),
    .resetn(resetn),
    .req   (req),
`ifdef RAND_LIMIT_EN
    .limit (limit),
`endif
    .grant (grant),
    .ack   (ack),
    .rnd   (rnd),
    .busy  (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] reqValue);
    req = reqValue;
  endtask

  // Count negedges from the drive point until ack shows, bounded at 300.
  task automatic waitForAck(output int lat, output logic [N-1:0] grantE0);
    @(negedge clock);
    lat     = 1;
    grantE0 = grant;
    while (ack == '0 && lat < 300) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic pulseReset();
    @(negedge clock);
    resetn = 1'b0;
    applyStimulus('0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  int           lat;
  logic [N-1:0] gE0;
  logic         sawAck;
  logic         grantMoved;

  initial begin
    resetn = 1'b0;
    req    = '0;
`ifdef RAND_LIMIT_EN
    limit  = 13'h1FFF;
`endif
    repeat (2) @(negedge clock);
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_ack",   32'(ack),   32'h0);
    checkOutput("rst_rnd",   32'(rnd),   32'h0);
    checkOutput("rst_busy",  32'(busy),  32'h0);
    resetn = 1'b1;
    @(negedge clock);

    // First delivery from SEED to requester 0.
    applyStimulus(4'b0001);
    waitForAck(lat, gE0);
    checkOutput("t1_grantE0", 32'(gE0),   32'h1);
    checkOutput("t1_latency", 32'(lat),   32'd14);
    checkOutput("t1_ack",     32'(ack),   32'h1);
    checkOutput("t1_rnd",     32'(rnd),   32'h1FF4);
    checkOutput("t1_grantHeld", 32'(grant), 32'h1);
    checkOutput("t1_busy",    32'(busy),  32'h1);
    applyStimulus('0);
    @(negedge clock);
    checkOutput("t1_ackPulse", 32'(ack),  32'h0);
    checkOutput("t1_grantClr", 32'(grant), 32'h0);
    checkOutput("t1_busyClr",  32'(busy), 32'h0);
    checkOutput("t1_rndHold",  32'(rnd),  32'h1FF4);

    // Re-raise requester 0 for the second word.
    applyStimulus(4'b0001);
    waitForAck(lat, gE0);
    checkOutput("t2_latency", 32'(lat), 32'd14);
    checkOutput("t2_ack",     32'(ack), 32'h1);
    checkOutput("t2_rnd",     32'(rnd), 32'h05E4);
    applyStimulus('0);

    // All four requesting continuously; grants rotate 0,1,2,3,0.
    pulseReset();
    applyStimulus(4'b1111);
    for (int k = 0; k < 5; k++) begin
      waitForAck(lat, gE0);
      checkOutput($sformatf("t3_latency%0d", k), 32'(lat), (k == 0) ? 32'd14 : 32'd15);
      checkOutput($sformatf("t3_ack%0d", k),     32'(ack),   32'(4'b0001 << (k % 4)));
      checkOutput($sformatf("t3_grant%0d", k),   32'(grant), 32'(4'b0001 << (k % 4)));
    end
    applyStimulus('0);
    @(negedge clock);

    // Reset seven cycles into a transaction for requester 2.
    applyStimulus(4'b0100);
    repeat (7) @(negedge clock);
    checkOutput("t4_grantPre", 32'(grant), 32'h4);
    checkOutput("t4_busyPre",  32'(busy),  32'h1);
    resetn = 1'b0;
    applyStimulus('0);
    #1;
    checkOutput("t4_grantRst", 32'(grant), 32'h0);
    checkOutput("t4_ackRst",   32'(ack),   32'h0);
    checkOutput("t4_rndRst",   32'(rnd),   32'h0);
    checkOutput("t4_busyRst",  32'(busy),  32'h0);
    @(negedge clock);
    resetn = 1'b1;
    sawAck = 1'b0;
    repeat (16) begin
      @(negedge clock);
      if (ack != '0) sawAck = 1'b1;
    end
    checkOutput("t4_noAck", 32'(sawAck), 32'h0);
    applyStimulus(4'b0100);
    waitForAck(lat, gE0);
    checkOutput("t4_latency", 32'(lat), 32'd14);
    checkOutput("t4_ack",     32'(ack), 32'h4);
    checkOutput("t4_rnd",     32'(rnd), 32'h1FF4);
    applyStimulus('0);
    @(negedge clock);

`ifdef RAND_LIMIT_EN
    // 0x1FF4 exceeds 0x0FFF and is rejected; the next word 0x05E4 fits.
    limit = 13'h0FFF;
    pulseReset();
    applyStimulus(4'b0010);
    waitForAck(lat, gE0);
    checkOutput("t5_latency", 32'(lat), 32'd28);
    checkOutput("t5_ack",     32'(ack), 32'h2);
    checkOutput("t5_rnd",     32'(rnd), 32'h05E4);
    applyStimulus('0);
    @(negedge clock);

    // A limit of 0 forces every retry and then the final mask; req toggles are ignored.
    limit = 13'h0000;
    pulseReset();
    applyStimulus(4'b0010);
    @(negedge clock);
    lat = 1;
    checkOutput("t6_grantE0", 32'(grant), 32'h2);
    limit      = 13'h1FFF;
    grantMoved = 1'b0;
    while (ack == '0 && lat < 300) begin
      applyStimulus((lat % 2 == 0) ? 4'b1101 : 4'b0000);
      @(negedge clock);
      lat++;
      if (grant != 4'b0010) grantMoved = 1'b1;
    end
    checkOutput("t6_grantStable", 32'(grantMoved), 32'h0);
    checkOutput("t6_latency",     32'(lat), 32'd56);
    checkOutput("t6_ack",         32'(ack), 32'h2);
    checkOutput("t6_rnd",         32'(rnd), 32'h0);
    applyStimulus('0);
    @(negedge clock);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
